// File: rtl/branch_predictor_bht.sv
// PC-indexed branch predictor with a tagged branch target buffer.
// Fetch looks up combinationally; execute writes back the resolved outcome.
// Indexing is bimodal (MODE 0) or gshare (MODE 1, PC index XOR global history).
// HIST_BITS must not exceed INDEX_BITS; CTR_WIDTH must be at least 1.
module branch_predictor_bht #(
    parameter int INDEX_BITS = 6,
    parameter int CTR_WIDTH  = 2,
    parameter int HIST_BITS  = 6,
    parameter int MODE       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           lookup_pc,
    output logic                  predict_valid,
    output logic                  predict_taken,
    output logic [31:0]           predict_target,
    output logic [INDEX_BITS-1:0] predict_index,
    input  logic                  update_valid,
    input  logic [31:0]           update_pc,
    input  logic [INDEX_BITS-1:0] update_index,
    input  logic                  update_taken,
    input  logic [31:0]           update_target,
    output logic [15:0]           mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WT - CTR_WIDTH'(1);

    // Read views of the per-entry state held in the generate blocks below
    logic [ENTRIES-1:0]   w_valid;
    logic [TAG_W-1:0]     w_tag    [ENTRIES];
    logic [31:0]          w_target [ENTRIES];
    logic [CTR_WIDTH-1:0] w_ctr    [ENTRIES];

    logic [HIST_BITS-1:0] r_ghr;
    logic [15:0]          r_mis_cnt;

    logic [INDEX_BITS-1:0] w_hist;
    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_W-1:0]      w_lk_tag;
    logic                  w_lk_hit;

    logic [TAG_W-1:0]      w_up_tag;
    logic                  w_up_hit;
    logic [CTR_WIDTH-1:0]  w_up_ctr;
    logic [CTR_WIDTH-1:0]  w_ctr_next;
    logic                  w_mispredict;

    // Byte-offset bits and the update PC's index field never affect state:
    // the index travels separately on update_index.
    logic w_unused;
    assign w_unused = ^{lookup_pc[1:0], update_pc[INDEX_BITS+1:0]};

    // ------------------------------------------------------------------
    // Lookup path (zero latency, no bypass of a same-cycle update)
    // ------------------------------------------------------------------
    // History is held at zero while reset is asserted so the index is pure PC.
    assign w_hist   = (MODE == 1 && !reset) ? INDEX_BITS'(r_ghr) : '0;
    assign w_lk_idx = lookup_pc[INDEX_BITS+1:2] ^ w_hist;
    assign w_lk_tag = lookup_pc[31:INDEX_BITS+2];
    assign w_lk_hit = !reset && w_valid[w_lk_idx] && (w_tag[w_lk_idx] == w_lk_tag);

    assign predict_index  = w_lk_idx;
    assign predict_valid  = w_lk_hit;
    assign predict_taken  = w_lk_hit && w_ctr[w_lk_idx][CTR_WIDTH-1];
    assign predict_target = w_lk_hit ? w_target[w_lk_idx] : 32'h0;

    // ------------------------------------------------------------------
    // Update path: read the addressed entry, work out its next counter
    // ------------------------------------------------------------------
    assign w_up_tag = update_pc[31:INDEX_BITS+2];
    assign w_up_hit = w_valid[update_index] && (w_tag[update_index] == w_up_tag);
    assign w_up_ctr = w_ctr[update_index];

    // A hit is judged by the pre-update counter MSB; a miss counts only if taken
    assign w_mispredict = w_up_hit ? (w_up_ctr[CTR_WIDTH-1] != update_taken)
                                   : update_taken;

    // Saturating train on hit/empty entry, weak re-seed on replacement
    always_comb begin
        w_ctr_next = w_up_ctr;
        if (!w_valid[update_index] || w_up_hit) begin
            if (update_taken) begin
                if (w_up_ctr != CTR_MAX) w_ctr_next = w_up_ctr + CTR_WIDTH'(1);
            end else begin
                if (w_up_ctr != '0) w_ctr_next = w_up_ctr - CTR_WIDTH'(1);
            end
        end else begin
            w_ctr_next = update_taken ? CTR_WT : CTR_WNT;
        end
    end

    // ------------------------------------------------------------------
    // Table entries, one block each
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic                 r_valid;
            logic [TAG_W-1:0]     r_tag;
            logic [31:0]          r_target;
            logic [CTR_WIDTH-1:0] r_ctr;
            logic                 w_we;

            assign w_we = update_valid && (update_index == INDEX_BITS'(gi));

            // Entry write: reset clears it, an update addressed here rewrites it
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_valid  <= 1'b0;
                    r_tag    <= '0;
                    r_target <= 32'h0;
                    r_ctr    <= CTR_WNT;
                end else if (w_we) begin
                    r_valid  <= 1'b1;
                    r_tag    <= w_up_tag;
                    r_target <= update_target;
                    r_ctr    <= w_ctr_next;
                end
            end

            assign w_valid[gi]  = r_valid;
            assign w_tag[gi]    = r_tag;
            assign w_target[gi] = r_target;
            assign w_ctr[gi]    = r_ctr;
        end
    endgenerate

    // Global history shifts in resolved outcomes only (non-speculative)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (update_valid) begin
            r_ghr <= HIST_BITS'({r_ghr, update_taken});
        end
    end

    // Saturating misprediction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mis_cnt <= 16'h0;
        end else if (update_valid && w_mispredict && (r_mis_cnt != 16'hFFFF)) begin
            r_mis_cnt <= r_mis_cnt + 16'h1;
        end
    end

    assign mispredict_count = r_mis_cnt;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: a bimodal and a gshare instance share stimulus
// and are each compared against a table-level reference model.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [5:0]  update_index;
    logic        update_taken;
    logic [31:0] update_target;

    logic        pv0, pt0, pv1, pt1;
    logic [31:0] ptg0, ptg1;
    logic [5:0]  pi0, pi1;
    logic [15:0] mc0, mc1;

    always #5 clk = ~clk;

    branch_predictor_bht #(.INDEX_BITS(6), .CTR_WIDTH(2), .HIST_BITS(6), .MODE(0)) u_bim (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .predict_valid(pv0), .predict_taken(pt0), .predict_target(ptg0), .predict_index(pi0),
        .update_valid(update_valid), .update_pc(update_pc), .update_index(update_index),
        .update_taken(update_taken), .update_target(update_target), .mispredict_count(mc0)
    );

    branch_predictor_bht #(.INDEX_BITS(6), .CTR_WIDTH(2), .HIST_BITS(6), .MODE(1)) u_gsh (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .predict_valid(pv1), .predict_taken(pt1), .predict_target(ptg1), .predict_index(pi1),
        .update_valid(update_valid), .update_pc(update_pc), .update_index(update_index),
        .update_taken(update_taken), .update_target(update_target), .mispredict_count(mc1)
    );

    wire [39:0] obs0 = {pv0, pt0, ptg0, pi0};
    wire [39:0] obs1 = {pv1, pt1, ptg1, pi1};

    int total = 0;
    int bad   = 0;

    // Reference model: m = 0 bimodal, m = 1 gshare
    bit          mv   [2][64];
    int unsigned mtag [2][64];
    int unsigned mtgt [2][64];
    int          mctr [2][64];
    int          mghr [2];
    int          mmis [2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) begin
                mv[m][i] = 1'b0; mtag[m][i] = 0; mtgt[m][i] = 0; mctr[m][i] = 1;
            end
            mghr[m] = 0;
            mmis[m] = 0;
        end
    endfunction

    function automatic void model_update(int m, logic [31:0] pc, int idx, bit tk, logic [31:0] tg);
        int unsigned tag = pc >> 8;
        bit hit = mv[m][idx] && (mtag[m][idx] == tag);
        bit mis = hit ? ((mctr[m][idx] >= 2) != tk) : tk;
        if (mis && mmis[m] < 65535) mmis[m]++;
        if (!mv[m][idx] || hit) begin
            if (tk) mctr[m][idx] = (mctr[m][idx] == 3) ? 3 : mctr[m][idx] + 1;
            else    mctr[m][idx] = (mctr[m][idx] == 0) ? 0 : mctr[m][idx] - 1;
        end else begin
            mctr[m][idx] = tk ? 2 : 1;
        end
        mv[m][idx]   = 1'b1;
        mtag[m][idx] = tag;
        mtgt[m][idx] = tg;
        mghr[m]      = ((mghr[m] << 1) | int'(tk)) % 64;
    endfunction

    function automatic logic [39:0] model_lookup(int m, logic [31:0] pc);
        int idx = int'((pc >> 2) % 64) ^ ((m == 1) ? mghr[m] : 0);
        bit v = mv[m][idx] && (mtag[m][idx] == (pc >> 8));
        bit t = v && (mctr[m][idx] >= 2);
        logic [31:0] tg = v ? mtgt[m][idx] : 32'h0;
        logic [5:0] i6 = 6'(idx);
        return {v, t, tg, i6};
    endfunction

    // Advance one clock edge and mirror what the DUTs commit on it
    task automatic tick();
        bit rst = reset;
        bit up  = update_valid;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else if (up) begin
            model_update(0, update_pc, int'(update_index), update_taken, update_target);
            model_update(1, update_pc, int'(update_index), update_taken, update_target);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [5:0] idx,
                         input bit tk, input logic [31:0] tg, input logic [31:0] lpc);
        update_valid  = v;
        update_pc     = pc;
        update_index  = idx;
        update_taken  = tk;
        update_target = tg;
        lookup_pc     = lpc;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] exp;
        // reset asserted together with an update: the write must not land
        reset = 1'b1;
        drive(1'b1, 32'h100, 6'h0, 1'b1, 32'h180, 32'h100);
        total++; if (obs0 !== 40'h0) begin bad++; $display("FAIL reset_during_dut0 got=%h want=%h", obs0, 40'h0); end
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h100);
        exp = model_lookup(0, lookup_pc);
        total++; if (obs0 !== 40'h0 || obs0 !== exp) begin bad++; $display("FAIL reset_lookup_dut0 got=%h want=%h", obs0, exp); end
        exp = model_lookup(1, lookup_pc);
        total++; if (obs1 !== 40'h0 || obs1 !== exp) begin bad++; $display("FAIL reset_lookup_dut1 got=%h want=%h", obs1, exp); end
        total++; if (mc0 !== 16'h0 || mc1 !== 16'h0) begin bad++; $display("FAIL reset_count got=%h/%h want=0", mc0, mc1); end
    endtask

    task automatic test_train_taken();
        logic [39:0] exp;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h100, 6'h0, 1'b1, 32'h180, 32'h100);
            tick();
            drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h100);
            total++; if (obs0 !== {1'b1, 1'b1, 32'h180, 6'h0}) begin bad++; $display("FAIL train_lookup_dut0 step=%0d got=%h want=%h", k, obs0, {1'b1, 1'b1, 32'h180, 6'h0}); end
            exp = model_lookup(1, lookup_pc);
            total++; if (obs1 !== exp) begin bad++; $display("FAIL train_lookup_dut1 step=%0d got=%h want=%h", k, obs1, exp); end
        end
        total++; if (mc0 !== 16'd1) begin bad++; $display("FAIL train_count_dut0 got=%0d want=1", mc0); end
        total++; if (mc1 !== 16'(mmis[1])) begin bad++; $display("FAIL train_count_dut1 got=%0d want=%0d", mc1, mmis[1]); end
    endtask

    task automatic test_not_taken();
        logic [39:0] exp;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100, 6'h0, 1'b0, 32'h180, 32'h100);
            tick();
            drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h100);
            exp = model_lookup(0, lookup_pc);
            total++; if (obs0 !== exp) begin bad++; $display("FAIL nt_lookup_dut0 step=%0d got=%h want=%h", k, obs0, exp); end
            exp = model_lookup(1, lookup_pc);
            total++; if (obs1 !== exp) begin bad++; $display("FAIL nt_lookup_dut1 step=%0d got=%h want=%h", k, obs1, exp); end
            if (k == 1) begin
                total++; if (pt0 !== 1'b0) begin bad++; $display("FAIL nt_taken_after2 got=%b want=0", pt0); end
            end
        end
        total++; if (mc0 !== 16'd3) begin bad++; $display("FAIL nt_count_dut0 got=%0d want=3", mc0); end
        total++; if (mc1 !== 16'(mmis[1])) begin bad++; $display("FAIL nt_count_dut1 got=%0d want=%0d", mc1, mmis[1]); end
    endtask

    task automatic test_alias();
        logic [39:0] exp;
        do_reset();
        drive(1'b1, 32'h100, 6'h0, 1'b1, 32'h180, 32'h200);
        tick();
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h200);
        total++; if (pv0 !== 1'b0) begin bad++; $display("FAIL alias_miss got=%b want=0", pv0); end
        drive(1'b1, 32'h200, 6'h0, 1'b0, 32'h280, 32'h100);
        tick();
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h100);
        exp = model_lookup(0, lookup_pc);
        total++; if (pv0 !== 1'b0 || obs0 !== exp) begin bad++; $display("FAIL alias_old_evicted got=%h want=%h", obs0, exp); end
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h200);
        total++; if (obs0 !== {1'b1, 1'b0, 32'h280, 6'h0}) begin bad++; $display("FAIL alias_new_entry got=%h want=%h", obs0, {1'b1, 1'b0, 32'h280, 6'h0}); end
    endtask

    task automatic test_gshare();
        logic [39:0] exp;
        logic [31:0] lpc;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h40, 6'h10, (k != 1), 32'h400, 32'h0);
            tick();
        end
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h100);
        total++; if (pi1 !== 6'h05 || pi0 !== 6'h00) begin bad++; $display("FAIL gshare_index got=%h/%h want=05/00", pi1, pi0); end
        // first write of entry 5, lookup of entry 5 in the same cycle
        drive(1'b1, 32'h100, 6'h05, 1'b1, 32'h500, 32'h100);
        total++; if (pv1 !== 1'b0) begin bad++; $display("FAIL gshare_same_cycle_empty got=%b want=0", pv1); end
        tick();
        // second write of entry 5 while looking it up: old target must show
        lpc = 32'h100 | (32'(5 ^ mghr[1]) << 2);
        drive(1'b1, 32'h100, 6'h05, 1'b1, 32'h600, lpc);
        total++; if (obs1 !== {1'b1, 1'b1, 32'h500, 6'h05}) begin bad++; $display("FAIL gshare_same_cycle_old got=%h want=%h", obs1, {1'b1, 1'b1, 32'h500, 6'h05}); end
        tick();
        lpc = 32'h100 | (32'(5 ^ mghr[1]) << 2);
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, lpc);
        exp = model_lookup(1, lookup_pc);
        total++; if (obs1 !== {1'b1, 1'b1, 32'h600, 6'h05} || obs1 !== exp) begin bad++; $display("FAIL gshare_next_cycle_new got=%h want=%h", obs1, exp); end
        exp = model_lookup(0, lookup_pc);
        total++; if (obs0 !== exp) begin bad++; $display("FAIL gshare_bimodal_side got=%h want=%h", obs0, exp); end
    endtask

    task automatic test_reset_mid_update();
        drive(1'b1, 32'h100, 6'h0, 1'b1, 32'h180, 32'h100);
        tick();
        reset = 1'b1;
        drive(1'b1, 32'h100, 6'h0, 1'b1, 32'h190, 32'h100);
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h100);
        total++; if (obs0 !== 40'h0 || obs1 !== 40'h0) begin bad++; $display("FAIL reset_mid_lookup got=%h/%h want=0/0", obs0, obs1); end
        total++; if (mc0 !== 16'h0 || mc1 !== 16'h0) begin bad++; $display("FAIL reset_mid_count got=%h/%h want=0/0", mc0, mc1); end
    endtask

    task automatic test_random();
        logic [39:0] exp0, exp1;
        logic [31:0] upc, lpc;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            upc = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            lpc = (32'($urandom_range(1, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            drive(($urandom % 4) != 0, upc, upc[7:2], $urandom % 2, $urandom, lpc);
            exp0 = model_lookup(0, lookup_pc);
            exp1 = model_lookup(1, lookup_pc);
            total++; if (obs0 !== exp0) begin bad++; $display("FAIL rand_lookup_dut0 it=%0d got=%h want=%h", k, obs0, exp0); end
            total++; if (obs1 !== exp1) begin bad++; $display("FAIL rand_lookup_dut1 it=%0d got=%h want=%h", k, obs1, exp1); end
            total++; if (mc0 !== 16'(mmis[0]) || mc1 !== 16'(mmis[1])) begin bad++; $display("FAIL rand_count it=%0d got=%0d/%0d want=%0d/%0d", k, mc0, mc1, mmis[0], mmis[1]); end
            tick();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        // alternating tags replace entry 0 each time: every update is a taken miss
        for (int k = 0; k < 65540; k++) begin
            drive(1'b1, (k % 2 == 0) ? 32'h100 : 32'h200, 6'h0, 1'b1, 32'h180, 32'h100);
            tick();
            if (k == 65533) begin
                total++; if (mc0 !== 16'hFFFE) begin bad++; $display("FAIL sat_before got=%h want=fffe", mc0); end
            end
        end
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h100);
        total++; if (mc0 !== 16'hFFFF || mc0 !== 16'(mmis[0])) begin bad++; $display("FAIL sat_dut0 got=%h want=ffff", mc0); end
        total++; if (mc1 !== 16'hFFFF || mc1 !== 16'(mmis[1])) begin bad++; $display("FAIL sat_dut1 got=%h want=ffff", mc1); end
    endtask

    initial begin
        model_reset();
        reset = 1'b0;
        drive(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_train_taken();
        test_not_taken();
        test_alias();
        test_gshare();
        test_reset_mid_update();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
